// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter for NUM_PORTS L1 requesters sharing one L2 bus: IDLE -> HOLD -> TURN.
// Optional forced-revoke timer under macro ARB_TIMEOUT_EN; `release` is reserved, so that port is release_pulse.
module bus_rr_arbiter #(
    parameter int NUM_PORTS      = 4,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int SEL_BITS      = $clog2(NUM_PORTS + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] release_pulse,
    input  logic                 l2_drive,
    output logic [NUM_PORTS-1:0] grant,
    output logic [SEL_BITS-1:0]  bus_control,
    output logic                 bus_en,
    output logic                 timeout,
    output logic [1:0]           dbg_state
);

    localparam int IDX_BITS = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        TURN = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [IDX_BITS-1:0]  master;
    logic [IDX_BITS-1:0]  last_master;
    logic [IDX_BITS-1:0]  win_idx;
    logic [IDX_BITS-1:0]  cand_idx;
    logic                 win_found;
    logic                 rel_hit;
    logic                 expire;
    int                   cand;

    // Only the current master's release ends the tenure.
    assign rel_hit   = release_pulse[master];
    assign dbg_state = state;

    // Search order starts one past the previous winner and wraps.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand     = (int'(last_master) + 1 + i) % NUM_PORTS;
            cand_idx = IDX_BITS'(cand);
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_found) state_nxt = HOLD;
            HOLD:    if (rel_hit || expire) state_nxt = TURN;
            TURN:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus_en      = 1'b0;
        bus_control = '0;
        if (state == HOLD) begin
            bus_en      = 1'b1;
            bus_control = l2_drive ? SEL_BITS'(NUM_PORTS) : SEL_BITS'(master);
        end
    end

    // Reset leaves last_master at the top port so port 0 wins first.
    always_ff @(posedge clock) begin
        if (reset) begin
            grant       <= '0;
            master      <= '0;
            last_master <= IDX_BITS'(NUM_PORTS - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        grant       <= NUM_PORTS'(1) << win_idx;
                        master      <= win_idx;
                        last_master <= win_idx;
                    end
                end
                HOLD: begin
                    if (rel_hit || expire) grant <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_BITS-1:0] hold_cnt;
    logic                timeout_q;

    // Fires in the last allowed HOLD cycle; a coincident release wins.
    assign expire  = (state == HOLD) && !rel_hit &&
                     (hold_cnt == CNT_BITS'(TIMEOUT_CYCLES - 1));
    assign timeout = timeout_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= expire;
            if (state == HOLD) hold_cnt <= hold_cnt + 1'b1;
            else               hold_cnt <= '0;
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter: reset, round-robin order, wrap, HOLD immunity,
// bus_control muxing, reset abort and the optional timeout (ARB_TIMEOUT_EN).
module tb_bus_rr_arbiter;

    localparam int N  = 4;
    localparam int SB = 3;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_TURN = 2'd2;

    logic          clock = 1'b0;
    logic          reset;
    logic [N-1:0]  req;
    logic [N-1:0]  release_pulse;
    logic          l2_drive;
    logic [N-1:0]  grant;
    logic [SB-1:0] bus_control;
    logic          bus_en;
    logic          timeout;
    logic [1:0]    dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    bus_rr_arbiter #(.NUM_PORTS(N), .TIMEOUT_CYCLES(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .req           (req),
        .release_pulse (release_pulse),
        .l2_drive      (l2_drive),
        .grant         (grant),
        .bus_control   (bus_control),
        .bus_en        (bus_en),
        .timeout       (timeout),
        .dbg_state     (dbg_state)
    );

    always #5 clock = ~clock;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; req = '0; release_pulse = '0; l2_drive = 1'b0;
        step(); step();
        reset = 1'b0;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_bus_en", 32'(bus_en), 32'h0);
        check("rst_bus_control", 32'(bus_control), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));

        // All request: port 0 first, one TURN, then port 1
        req = 4'b1111;
        step();
        check("first_grant", 32'(grant), 32'h1);
        check("first_bus_en", 32'(bus_en), 32'h1);
        check("first_bus_control", 32'(bus_control), 32'h0);
        release_pulse = 4'b0001;
        step();
        release_pulse = '0;
        check("turn_grant", 32'(grant), 32'h0);
        check("turn_bus_en", 32'(bus_en), 32'h0);
        check("turn_state", 32'(dbg_state), 32'(S_TURN));
        step();
        check("idle_after_turn", 32'(dbg_state), 32'(S_IDLE));
        check("idle_grant", 32'(grant), 32'h0);
        step();
        check("second_grant", 32'(grant), 32'h2);

        // HOLD ignores foreign release and own req drop
        release_pulse = 4'b0100;
        step();
        release_pulse = '0;
        check("foreign_release", 32'(grant), 32'h2);
        req = 4'b1101;
        step();
        check("req_drop", 32'(grant), 32'h2);
        check("hold_state", 32'(dbg_state), 32'(S_HOLD));
        req = '0; release_pulse = 4'b0010;
        step();
        release_pulse = '0;
        check("m1_released", 32'(grant), 32'h0);
        step();

        // bus_control muxing for master 2 and release with l2_drive
        req = 4'b0100;
        step();
        req = '0;
        check("m2_grant", 32'(grant), 32'h4);
        l2_drive = 1'b1; #1;
        check("m2_l2_ctrl", 32'(bus_control), 32'h4);
        check("m2_l2_en", 32'(bus_en), 32'h1);
        l2_drive = 1'b0; #1;
        check("m2_l1_ctrl", 32'(bus_control), 32'h2);
        release_pulse = 4'b0100; l2_drive = 1'b1; #1;
        check("rel_l2_ctrl", 32'(bus_control), 32'h4);
        step();
        release_pulse = '0; l2_drive = 1'b0;
        check("rel_l2_turn", 32'(dbg_state), 32'(S_TURN));
        check("rel_l2_grant", 32'(grant), 32'h0);
        check("turn_ctrl", 32'(bus_control), 32'h0);
        step();

        // Wrap-around: 3 then 0 then 3
        req = 4'b1000;
        step();
        check("m3_grant", 32'(grant), 32'h8);
        check("m3_ctrl", 32'(bus_control), 32'h3);
        req = 4'b1001; release_pulse = 4'b1000;
        step();
        release_pulse = '0;
        step(); step();
        check("wrap_grant", 32'(grant), 32'h1);
        release_pulse = 4'b0001;
        step();
        release_pulse = '0;
        step(); step();
        check("back_to_3", 32'(grant), 32'h8);
        req = '0; release_pulse = 4'b1000;
        step();
        release_pulse = '0;
        step();

        // Reset mid-HOLD of port 1: no TURN, and port 1 wins again before 2/3
        req = 4'b0010;
        step();
        check("pre_rst_grant", 32'(grant), 32'h2);
        reset = 1'b1; req = '0;
        step();
        reset = 1'b0;
        check("midrst_grant", 32'(grant), 32'h0);
        check("midrst_bus_en", 32'(bus_en), 32'h0);
        check("midrst_state", 32'(dbg_state), 32'(S_IDLE));
        req = 4'b1110;
        step();
        req = '0;
        check("post_rst_grant", 32'(grant), 32'h2);
        release_pulse = 4'b0010;
        step();
        release_pulse = '0;
        step();

        // Long HOLD without release
        req = 4'b0001;
        step();
        req = '0;
        check("long_grant", 32'(grant), 32'h1);
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            step();
            check("to_pending_grant", 32'(grant), 32'h1);
            check("to_pending_pulse", 32'(timeout), 32'h0);
        end
        step();
        check("to_pulse", 32'(timeout), 32'h1);
        check("to_grant", 32'(grant), 32'h0);
        check("to_state", 32'(dbg_state), 32'(S_TURN));
        step();
        check("to_pulse_end", 32'(timeout), 32'h0);
        check("to_idle", 32'(dbg_state), 32'(S_IDLE));
`else
        repeat (1000) step();
        check("hold_1000_grant", 32'(grant), 32'h1);
        check("hold_1000_timeout", 32'(timeout), 32'h0);
        release_pulse = 4'b0001;
        step();
        release_pulse = '0;
        check("hold_1000_release", 32'(grant), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bus_rr_arbiter.md
BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, meaning the number of L1 requester ports sharing the bus.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 256, meaning the maximum number of HOLD cycles before forced revoke (used only with the macro in REQ-027).
REQ-003 SHALL derive localparam SEL_BITS = log2(NUM_PORTS+1), the width of the bus select.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port req, input, NUM_PORTS bits: per-L1 bus request, level-sensitive.
REQ-007 SHALL have port release, input, NUM_PORTS bits: per-L1 end-of-transaction pulse.
REQ-008 SHALL have port l2_drive, input, 1 bit: the L2 is driving the response phase of the current transaction.
REQ-009 SHALL have port grant, output, NUM_PORTS bits: one-hot bus master indication.
REQ-010 SHALL have port bus_control, output, SEL_BITS bits: mux_bus enable_port select.
REQ-011 SHALL have port bus_en, output, 1 bit: mux_bus valid_enable.
REQ-012 SHALL have port timeout, output, 1 bit: one-cycle pulse on forced revoke.

Function
REQ-013 SHALL implement three registered states: IDLE, HOLD and TURN.
REQ-014 In IDLE with req nonzero, SHALL select the winner by round-robin search starting at last_master+1 (mod NUM_PORTS), register grant one-hot and enter HOLD on the next edge (1-cycle request-to-grant latency).
REQ-015 In IDLE with req all zero, SHALL remain in IDLE with grant 0.
REQ-016 SHALL update last_master to the winner index on entry to HOLD.
REQ-017 In HOLD, SHALL keep grant constant and ignore req changes, including deassertion of the master's own req.
REQ-018 In HOLD, SHALL honour only release[master]; release on any other bit SHALL be ignored.
REQ-019 On release[master] in HOLD, SHALL enter TURN on the next edge and clear grant.
REQ-020 TURN SHALL last exactly one cycle with bus_en=0 (bus turnaround), then move to IDLE; requests pending during TURN are arbitrated in the following IDLE cycle.
REQ-021 SHALL set bus_en to 1 only in HOLD.
REQ-022 SHALL set bus_control to NUM_PORTS in HOLD when l2_drive=1, to the master index in HOLD when l2_drive=0, and to 0 otherwise; this output is combinational from state and l2_drive.
REQ-023 Simultaneous release[master] and l2_drive SHALL resolve as release (to TURN), with bus_control=NUM_PORTS for that final HOLD cycle.
REQ-024 Round-robin wrap-around: after last_master=NUM_PORTS-1, the search SHALL begin at port 0.

Reset
REQ-025 On reset=1 at a clock edge, SHALL enter IDLE and clear grant, timeout and the hold counter.
REQ-026 On reset, SHALL set last_master=NUM_PORTS-1 (port 0 wins first); reset in HOLD SHALL abort the grant with no TURN cycle.

Configuration
REQ-027 Macro ARB_TIMEOUT_EN defined: a hold counter SHALL count HOLD cycles; if HOLD persists TIMEOUT_CYCLES cycles without release, the arbiter SHALL enter TURN, clear grant and pulse timeout for exactly one cycle. The counter clears on HOLD entry.
REQ-028 Macro ARB_TIMEOUT_EN undefined: there SHALL be no counter logic, timeout is tied to 0 and HOLD persists until release.

Verification
REQ-029 After reset, req=4'b1111 -> grant=0001 one cycle later; release[0] -> one TURN cycle -> grant=0010.
REQ-030 With req=4'b1000 held and last_master=3, then req=4'b1001 -> grant order is 1000, then 0001 (wrap-around).
REQ-031 In HOLD for master 2, l2_drive=1 -> bus_control=4 and bus_en=1; l2_drive=0 -> bus_control=2.
REQ-032 In HOLD for master 1, release=4'b0100 -> grant stays 0010; req[1] dropping -> grant stays 0010.
REQ-033 reset asserted mid-HOLD -> next cycle grant=0, bus_en=0, and req=4'b0010 is granted before port 3.
REQ-034 ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8, no release -> timeout=1 for exactly one cycle after 8 HOLD cycles, then grant=0; without the macro, grant is still held after 1000 cycles.
